// File: rtl/dp_ctrl_pkg.sv
// Shared definitions for the DataPath boot controller: FSM state encoding,
// error codes and the default halt instruction.
package dp_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_PCRST = 3'd2,
        ST_RUN   = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERR   = 3'd5
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_OVF     = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    localparam logic [31:0] DEFAULT_HALT_WORD = 32'hFFFF_FFFF;

endpackage

// File: rtl/dp_cycle_counter.sv
// 16-bit saturating RUN-cycle counter with synchronous clear and a terminal
// flag that asserts when the count equals MAX_CYCLES-1.
module dp_cycle_counter #(
    parameter int unsigned MAX_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        en,
    output logic [15:0] count,
    output logic        terminal
);

    localparam logic [15:0] TERM_COUNT = 16'(MAX_CYCLES - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != 16'hFFFF)) begin
            count <= count + 16'd1;
        end
    end

    assign terminal = (count == TERM_COUNT);

endmodule

// File: rtl/dp_boot_ctrl.sv
// Boot sequencer for DataPath: streams a program image into instruction
// memory, pulses the PC reset, then runs until a halt word or a timeout.
module dp_boot_ctrl
    import dp_ctrl_pkg::*;
#(
    parameter int unsigned       DATA_W     = 32,
    parameter int unsigned       ADDR_W     = 8,
    parameter int unsigned       MAX_CYCLES = 1024,
    parameter logic [DATA_W-1:0] HALT_WORD  = DATA_W'(DEFAULT_HALT_WORD)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [DATA_W-1:0] im_wdata,
    input  logic [DATA_W-1:0] instr,
    output logic              dp_pc_rst,
    output logic              dp_run,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [ADDR_W:0]   word_count,
    output logic [15:0]       cycle_count
);

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] addr;
    logic              hs;
    logic              addr_max;
    logic              halt;
    logic              load_entry;
    logic              terminal;

    assign hs         = ld_valid && ld_ready;
    assign addr_max   = &addr;
    assign halt       = (instr == HALT_WORD);
    assign load_entry = start && ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR));

    dp_cycle_counter #(
        .MAX_CYCLES(MAX_CYCLES)
    ) u_cycle_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (state == ST_PCRST),
        .en       (state == ST_RUN),
        .count    (cycle_count),
        .terminal (terminal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) state_next = ST_LOAD;
            end
            ST_LOAD: begin
                if (hs) begin
                    if (ld_last)       state_next = ST_PCRST;
                    else if (addr_max) state_next = ST_ERR;
                end
            end
            ST_PCRST: state_next = ST_RUN;
            ST_RUN: begin
                // halt takes priority when it lands on the final allowed cycle
                if (halt)          state_next = ST_DONE;
                else if (terminal) state_next = ST_ERR;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        ld_ready  = 1'b0;
        dp_pc_rst = 1'b0;
        dp_run    = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        unique case (state)
            ST_LOAD: begin
                ld_ready = 1'b1;
                busy     = 1'b1;
            end
            ST_PCRST: begin
                dp_pc_rst = 1'b1;
                busy      = 1'b1;
            end
            ST_RUN: begin
                dp_run = !halt;
                busy   = 1'b1;
            end
            ST_DONE: done = 1'b1;
            ST_ERR:  err  = 1'b1;
            default: ;
        endcase
    end

    // Load-side datapath: one registered write per handshake, plus status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            im_we      <= 1'b0;
            im_addr    <= '0;
            im_wdata   <= '0;
            addr       <= '0;
            word_count <= '0;
            err_code   <= ERR_NONE;
        end else begin
            im_we <= 1'b0;
            if (load_entry) begin
                addr       <= '0;
                word_count <= '0;
                err_code   <= ERR_NONE;
            end
            if ((state == ST_LOAD) && hs) begin
                im_we      <= 1'b1;
                im_addr    <= addr;
                im_wdata   <= ld_data;
                addr       <= addr + ADDR_W'(1);
                word_count <= word_count + (ADDR_W + 1)'(1);
                if (!ld_last && addr_max) err_code <= ERR_OVF;
            end
            if ((state == ST_RUN) && !halt && terminal) begin
                err_code <= ERR_TIMEOUT;
            end
        end
    end

endmodule

// File: tb/tb_dp_boot_ctrl.sv
// Scoreboard bench for dp_boot_ctrl: a behavioural memory/PC model plays the
// DataPath, and expected writes and run outcomes are queued for a monitor.
module tb_dp_boot_ctrl;

    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 2;
    localparam int unsigned MAXC  = 8;
    localparam int          DEPTH = 4;
    localparam logic [31:0] HALT  = 32'hFFFF_FFFF;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b1;
    logic          start    = 1'b0;
    logic          ld_valid = 1'b0;
    logic [DW-1:0] ld_data  = '0;
    logic          ld_last  = 1'b0;
    logic          ld_ready;
    logic          im_we;
    logic [AW-1:0] im_addr;
    logic [DW-1:0] im_wdata;
    logic [DW-1:0] instr;
    logic          dp_pc_rst;
    logic          dp_run;
    logic          busy;
    logic          done;
    logic          err;
    logic [1:0]    err_code;
    logic [AW:0]   word_count;
    logic [15:0]   cycle_count;

    always #5 clk = ~clk;

    dp_boot_ctrl #(
        .DATA_W     (DW),
        .ADDR_W     (AW),
        .MAX_CYCLES (MAXC),
        .HALT_WORD  (HALT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .ld_valid    (ld_valid),
        .ld_data     (ld_data),
        .ld_last     (ld_last),
        .ld_ready    (ld_ready),
        .im_we       (im_we),
        .im_addr     (im_addr),
        .im_wdata    (im_wdata),
        .instr       (instr),
        .dp_pc_rst   (dp_pc_rst),
        .dp_run      (dp_run),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .err_code    (err_code),
        .word_count  (word_count),
        .cycle_count (cycle_count)
    );

    // DataPath stand-in: instruction memory plus a PC gated by dp_run
    logic [31:0]   phys_mem [DEPTH] = '{default: '0};
    logic [AW-1:0] pc = '0;
    assign instr = phys_mem[pc];

    always @(posedge clk) begin
        if (im_we) phys_mem[im_addr] <= im_wdata;
        if (dp_pc_rst)   pc <= '0;
        else if (dp_run) pc <= pc + 1'b1;
    end

    typedef struct {
        int          addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        bit          is_err;
        logic [1:0]  code;
        int          wc;
        int          cycles;
        int          pcrst;
    } end_t;

    wr_t         wr_q[$];
    end_t        end_q[$];
    int          tests = 0;
    int          fails = 0;
    logic [31:0] ref_mem [DEPTH] = '{default: '0};
    logic [31:0] img [DEPTH];
    int          last_cycles = 0;
    bit          m_load  = 1'b0;
    bit          hs_flag = 1'b0;
    bit          exp_we  = 1'b0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual %0h, required %0h", name, act, exp);
        end
    endfunction

    function automatic logic [31:0] rnd_word();
        logic [31:0] w;
        w = $urandom;
        if (w == HALT) w = 32'h0;
        return w;
    endfunction

    // Outcome of a run from the reference memory image, by direct simulation
    function automatic end_t predict(input int n, input bit last_end);
        end_t e;
        int   p;
        e.wc    = n;
        e.pcrst = last_end ? 1 : 0;
        if (!last_end) begin
            e.is_err = 1'b1;
            e.code   = 2'b01;
            e.cycles = last_cycles;
        end else begin
            e.is_err = 1'b1;
            e.code   = 2'b10;
            e.cycles = MAXC;
            p = 0;
            for (int k = 0; k < int'(MAXC); k++) begin
                if (ref_mem[p] == HALT) begin
                    e.is_err = 1'b0;
                    e.code   = 2'b00;
                    e.cycles = k + 1;
                    break;
                end
                p = (p + 1) % DEPTH;
            end
            last_cycles = e.cycles;
        end
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ctl"}, {ld_ready, im_we, dp_pc_rst, dp_run, busy, done, err}, 0);
        chk({tag, "_err_code"}, err_code, 0);
        chk({tag, "_im_addr"}, im_addr, 0);
        chk({tag, "_im_wdata"}, im_wdata, 0);
        chk({tag, "_word_count"}, word_count, 0);
        chk({tag, "_cycle_count"}, cycle_count, 0);
    endtask

    // vmode: 0 = valid held, 1 = valid toggling, 2 = random valid
    task automatic load_image(input int n, input bit last_end, input int vmode,
                              input bit poke, input bit push_end);
        int a;
        int sent;
        start = 1'b1;
        step();
        start  = 1'b0;
        m_load = 1'b1;
        a      = 0;
        sent   = 0;
        for (int cyc = 0; cyc < 64 && sent < n; cyc++) begin
            case (vmode)
                0:       ld_valid = 1'b1;
                1:       ld_valid = (cyc % 2 == 0);
                default: ld_valid = ($urandom_range(0, 2) != 0);
            endcase
            ld_data = img[sent];
            ld_last = last_end && (sent == n - 1);
            start   = poke && ($urandom_range(0, 3) == 0);
            hs_flag = ld_valid;
            step();
            if (hs_flag) begin
                wr_q.push_back('{a, img[sent]});
                ref_mem[a] = img[sent];
                sent++;
                if (ld_last || a == DEPTH - 1) m_load = 1'b0;
                a++;
            end
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        start    = 1'b0;
        hs_flag  = 1'b0;
        chk("load_words_accepted", sent, n);
        if (push_end) end_q.push_back(predict(n, last_end));
    endtask

    task automatic wait_end(input string tag);
        int k;
        k = 0;
        while (!(done || err) && k < 100) begin
            step();
            k++;
        end
        chk({tag, "_end_reached"}, done | err, 1);
        step();
    endtask

    always @(posedge clk) exp_we <= hs_flag;

    // Monitor: checks every cycle and pops the scoreboard on writes and run ends
    initial begin
        bit   prev_end;
        int   pcrst_cnt;
        wr_t  w;
        end_t e;
        prev_end  = 1'b0;
        pcrst_cnt = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_end  = 1'b0;
                pcrst_cnt = 0;
            end else begin
                chk("ld_ready", ld_ready, m_load);
                chk("im_we", im_we, exp_we);
                if (im_we && wr_q.size() > 0) begin
                    w = wr_q.pop_front();
                    chk("im_addr", im_addr, w.addr);
                    chk("im_wdata", im_wdata, w.data);
                end
                if (dp_pc_rst) pcrst_cnt++;
                chk("pcrst_and_run", dp_pc_rst & dp_run, 0);
                chk("done_and_err", done & err, 0);
                if (m_load) chk("load_flags", {busy, done, err}, 3'b100);
                if (done || err) begin
                    chk("end_outputs", {busy, dp_run, ld_ready, dp_pc_rst}, 0);
                    if (!prev_end) begin
                        if (end_q.size() == 0) begin
                            tests++;
                            fails++;
                            $display("FAIL unexpected_end: done=%0b err=%0b, required no run end", done, err);
                        end else begin
                            e = end_q.pop_front();
                            chk("end_err", err, e.is_err);
                            chk("end_done", done, !e.is_err);
                            chk("err_code", err_code, e.code);
                            chk("word_count", word_count, e.wc);
                            chk("cycle_count", cycle_count, e.cycles);
                            chk("pc_rst_pulses", pcrst_cnt, e.pcrst);
                        end
                        pcrst_cnt = 0;
                    end
                end
                prev_end = done || err;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        bit last_end;
        int n;
        #1 rst_n = 1'b0;
        #1 check_all_zero("async_reset");
        step();
        step();
        rst_n = 1'b1;
        step();
        check_all_zero("idle_after_reset");

        // Directed image with held valid and halt on word 4
        img = '{32'h0000_0013, 32'h00A0_0093, 32'h0010_8113, 32'hFFFF_FFFF};
        load_image(4, 1'b1, 0, 1'b0, 1'b1);
        wait_end("directed4");

        // Toggling valid, three words; halt left at address 3
        for (int i = 0; i < DEPTH; i++) img[i] = rnd_word();
        load_image(3, 1'b1, 1, 1'b0, 1'b1);
        wait_end("toggle3");

        // Overflow: full depth without ld_last
        for (int i = 0; i < DEPTH; i++) img[i] = rnd_word();
        load_image(4, 1'b0, 2, 1'b0, 1'b1);
        wait_end("overflow");

        // Timeout: no halt anywhere in memory
        for (int i = 0; i < DEPTH; i++) img[i] = rnd_word();
        load_image(4, 1'b1, 0, 1'b0, 1'b1);
        wait_end("timeout");

        // Asynchronous reset on RUN cycle 3
        for (int i = 0; i < DEPTH; i++) img[i] = rnd_word();
        load_image(4, 1'b1, 0, 1'b0, 1'b0);
        step();
        step();
        step();
        chk("mid_run_busy", busy, 1);
        chk("mid_run_cycle_count", cycle_count, 2);
        rst_n = 1'b0;
        #1 check_all_zero("mid_run_reset");
        last_cycles = 0;
        step();
        rst_n = 1'b1;
        step();
        check_all_zero("idle_after_mid_run_reset");

        // Randomized images, with start pokes during LOAD and PCRST/RUN
        for (int it = 0; it < 16; it++) begin
            last_end = ($urandom_range(0, 4) != 0);
            n = last_end ? int'($urandom_range(1, DEPTH)) : DEPTH;
            for (int i = 0; i < DEPTH; i++)
                img[i] = ($urandom_range(0, 3) == 0) ? HALT : rnd_word();
            load_image(n, last_end, int'($urandom_range(0, 2)), 1'b1, 1'b1);
            if (last_end && $urandom_range(0, 1) == 1) begin
                start = 1'b1;
                step();
                step();
                start = 1'b0;
            end
            wait_end("random");
        end

        step();
        chk("wr_q_drained", wr_q.size(), 0);
        chk("end_q_drained", end_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
